sti_stream_tx: RTL and testbench

Parametrised, buffered successor to the 16-bit serial transmitter (STI). Parallel words are written into a small input FIFO with a ready/load handshake. A serialiser drains the FIFO and emits one bit per clock on `so_data`, qualified by `so_valid`. Words stream back-to-back with no idle gap, and `so_last` marks each word's final bit. The block sits between the parallel producer and the DAC/serial link and replaces the single-shot STI, which could hold only one word in flight.

---
 rtl/sti_stream_pkg.sv | 26 ++
 rtl/sti_stream_tx_if.sv | 30 +++
 rtl/sti_fifo.sv | 53 +++++
 rtl/sti_stream_tx.sv | 139 +++++++++++++
 tb/tb_sti_stream_tx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sti_stream_pkg.sv
// Shared types and helpers for the buffered serial transmitter.
package sti_stream_pkg;

  localparam int unsigned MAX_W    = 64;
  localparam int unsigned LEN_M1_W = $clog2(MAX_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // FIFO entry: right-aligned field, field length minus one, bit order.
  typedef struct packed {
    logic [MAX_W-1:0]    data;
    logic [LEN_M1_W-1:0] len_m1;
    logic                msb;
  } fifo_entry_t;

  // Field length in bits for a length code, saturated to the word width.
  function automatic int unsigned len_bits(input int unsigned code, input int unsigned data_w);
    int unsigned l;
    l = (code + 1) * 8;
    return (l > data_w) ? data_w : l;
  endfunction

endpackage

// File: rtl/sti_stream_tx_if.sv
// Parallel load side and serial output side of the transmitter.
interface sti_stream_tx_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned LEN_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              load;
  logic              pi_ready;
  logic [DATA_W-1:0] pi_data;
  logic [LEN_W-1:0]  pi_len;
  logic              pi_msb;
  logic              pi_low;
  logic              so_data;
  logic              so_valid;
  logic              so_last;
  logic [CNT_W-1:0]  fifo_cnt;

  modport master (
    output load, pi_data, pi_len, pi_msb, pi_low,
    input  pi_ready, so_data, so_valid, so_last, fifo_cnt
  );

  modport slave (
    input  load, pi_data, pi_len, pi_msb, pi_low,
    output pi_ready, so_data, so_valid, so_last, fifo_cnt
  );

endinterface

// File: rtl/sti_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
module sti_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sti_stream_tx.sv
// Buffered parallel-to-serial transmitter: field extraction, FIFO, serialiser.
module sti_stream_tx
  import sti_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input logic            clk,
  input logic            reset,
  sti_stream_tx_if.slave bus
);
  localparam int unsigned LEN_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = $bits(fifo_entry_t);

  logic [LEN_W-1:0]    len_code;
  int unsigned         field_len;
  logic [MAX_W-1:0]    data64;
  fifo_entry_t         push_entry;
  fifo_entry_t         pop_entry;
  logic [ENT_W-1:0]    pop_raw;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  state_t              state, state_d;
  logic [MAX_W-1:0]    sreg, sreg_d;
  logic [LEN_M1_W-1:0] bit_cnt, bit_cnt_d;
  logic                cur_msb, cur_msb_d;
  logic                load_word;
  logic                so_data_q, so_data_d;
  logic                so_valid_q, so_valid_d;
  logic                so_last_q, so_last_d;

  assign len_code     = bus.pi_len;
  assign fifo_push    = bus.load & ~fifo_full;
  assign bus.pi_ready = ~fifo_full;
  assign bus.fifo_cnt = fifo_count;
  assign bus.so_data  = so_data_q;
  assign bus.so_valid = so_valid_q;
  assign bus.so_last  = so_last_q;
  assign pop_entry    = fifo_entry_t'(pop_raw);

  // Extract the selected field, right-aligned, at push time.
  always_comb begin
    field_len = len_bits(32'(len_code), DATA_W);
    data64    = MAX_W'(bus.pi_data);
    push_entry.msb    = bus.pi_msb;
    push_entry.len_m1 = LEN_M1_W'(field_len - 1);
    if (bus.pi_low || field_len == DATA_W) begin
      push_entry.data = data64 & ~({MAX_W{1'b1}} << field_len);
    end else begin
      push_entry.data = data64 >> (DATA_W - field_len);
    end
  end

  sti_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (pop_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serialiser next state, shift datapath and next registered outputs.
  always_comb begin
    state_d    = state;
    sreg_d     = sreg;
    bit_cnt_d  = bit_cnt;
    cur_msb_d  = cur_msb;
    load_word  = 1'b0;
    fifo_pop   = 1'b0;
    so_data_d  = 1'b0;
    so_valid_d = 1'b0;
    so_last_d  = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load_word = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        so_data_d  = cur_msb ? sreg[MAX_W-1] : sreg[0];
        so_valid_d = 1'b1;
        so_last_d  = (bit_cnt == '0);
        sreg_d     = cur_msb ? {sreg[MAX_W-2:0], 1'b0} : {1'b0, sreg[MAX_W-1:1]};
        bit_cnt_d  = bit_cnt - LEN_M1_W'(1);
        if (bit_cnt == '0) begin
          if (!fifo_empty) load_word = 1'b1;
          else             state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // MSB-first words are left-aligned so both orders shift from a fixed end.
    if (load_word) begin
      fifo_pop  = 1'b1;
      bit_cnt_d = pop_entry.len_m1;
      cur_msb_d = pop_entry.msb;
      sreg_d    = pop_entry.msb
                ? (pop_entry.data << (LEN_M1_W'(MAX_W - 1) - pop_entry.len_m1))
                : pop_entry.data;
    end
  end

  // Serialiser state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      cur_msb    <= 1'b0;
      so_data_q  <= 1'b0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      bit_cnt    <= bit_cnt_d;
      cur_msb    <= cur_msb_d;
      so_data_q  <= so_data_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
    end
  end

endmodule

// File: tb/tb_sti_stream_tx.sv
// Self-checking bench for sti_stream_tx against a word/bit-queue model.
module tb_sti_stream_tx;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    logic [31:0] field;
    int          len;
    bit          msb;
  } word_t;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  word_t mq[$];
  word_t cur;
  int    cur_pos;
  bit    cur_act;

  int          cyc;
  logic [63:0] cap;
  int          cap_n;
  int          first_cyc;
  int          last_cyc;
  int          n_last;
  int          n_acc;

  sti_stream_tx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sti_stream_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Word as the serialiser should see it: L-bit field, right-aligned.
  function automatic word_t make_word(input logic [31:0] d, input logic [1:0] lc,
                                      input bit msb, input bit low);
    word_t       w;
    int          l;
    logic [63:0] d64;
    l   = (int'(lc) + 1) * 8;
    if (l > 32) l = 32;
    d64 = {32'd0, d};
    if (low || l == 32) w.field = 32'(d64 & ((64'd1 << l) - 64'd1));
    else                w.field = 32'(d64 >> (32 - l));
    w.len = l;
    w.msb = msb;
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    cur_act = 1'b0;
    cur_pos = 0;
  endtask

  task automatic clear_stats();
    cap = '0; cap_n = 0; first_cyc = -1; last_cyc = -1; n_last = 0; n_acc = 0;
  endtask

  // One clock: drive after negedge, advance the model at posedge, compare at posedge+1.
  task automatic step(input bit ld, input logic [31:0] d, input logic [1:0] lc,
                      input bit msb, input bit low);
    bit acc;
    bit e_d, e_v, e_l;
    int idx;
    bus.load    = ld;
    bus.pi_data = d;
    bus.pi_len  = lc;
    bus.pi_msb  = msb;
    bus.pi_low  = low;
    acc = ld && (mq.size() < DEPTH);
    check("pi_ready", 64'(bus.pi_ready), 64'(mq.size() < DEPTH));
    @(posedge clk);
    #1;
    cyc++;
    e_d = 1'b0; e_v = 1'b0; e_l = 1'b0;
    if (cur_act) begin
      idx = cur.msb ? (cur.len - 1 - cur_pos) : cur_pos;
      e_d = cur.field[idx];
      e_v = 1'b1;
      cur_pos++;
      if (cur_pos == cur.len) begin
        e_l     = 1'b1;
        cur_act = 1'b0;
      end
    end
    if (!cur_act && mq.size() > 0) begin
      cur     = mq.pop_front();
      cur_pos = 0;
      cur_act = 1'b1;
    end
    if (acc) begin
      mq.push_back(make_word(d, lc, msb, low));
      n_acc++;
    end
    check("so_data", 64'(bus.so_data), 64'(e_d));
    check("so_valid", 64'(bus.so_valid), 64'(e_v));
    check("so_last", 64'(bus.so_last), 64'(e_l));
    check("fifo_cnt", 64'(bus.fifo_cnt), 64'(mq.size()));
    if (bus.so_valid) begin
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      cap = {cap[62:0], bus.so_data};
      cap_n++;
    end
    if (bus.so_last) n_last++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom(), 2'($urandom()), 1'($urandom()), 1'($urandom()));
  endtask

  initial begin
    int  push_cyc;
    bit  found;

    cyc = 0;
    reset = 1'b0;
    bus.load = 1'b0; bus.pi_data = '0; bus.pi_len = '0; bus.pi_msb = 1'b0; bus.pi_low = 1'b0;
    model_reset();
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_so_data", 64'(bus.so_data), 64'd0);
    check("rst_so_valid", 64'(bus.so_valid), 64'd0);
    check("rst_so_last", 64'(bus.so_last), 64'd0);
    check("rst_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("rst_pi_ready", 64'(bus.pi_ready), 64'd1);
    reset = 1'b1;
    idle(2);

    // 16-bit low field, MSB first.
    clear_stats();
    push_cyc = cyc + 1;
    step(1'b1, 32'h0000_A5C3, 2'd1, 1'b1, 1'b1);
    idle(20);
    check("s1_bits", cap[15:0], 64'h0000_0000_0000_A5C3);
    check("s1_count", 64'(cap_n), 64'd16);
    check("s1_latency", 64'(first_cyc - push_cyc), 64'd2);
    check("s1_lasts", 64'(n_last), 64'd1);

    // 8-bit high field, LSB first.
    clear_stats();
    step(1'b1, 32'h8100_0000, 2'd0, 1'b0, 1'b0);
    idle(12);
    check("s2_bits", cap[7:0], 64'h81);
    check("s2_count", 64'(cap_n), 64'd8);

    // Full word, low ignored.
    clear_stats();
    step(1'b1, 32'hF000_000F, 2'd3, 1'b1, 1'b0);
    idle(36);
    check("s3_bits", cap[31:0], 64'hF000_000F);
    check("s3_count", 64'(cap_n), 64'd32);

    // Six consecutive 8-bit pushes: FIFO fills, the sixth is dropped.
    clear_stats();
    for (int i = 0; i < 6; i++) step(1'b1, $urandom(), 2'd0, 1'($urandom()), 1'($urandom()));
    idle(60);
    check("s4_accepted", 64'(n_acc), 64'd5);
    check("s4_bits", 64'(cap_n), 64'd40);
    check("s4_nogap", 64'(last_cyc - first_cyc + 1), 64'd40);
    check("s4_lasts", 64'(n_last), 64'd5);

    // Push coinciding with the pop of the only queued word.
    clear_stats();
    step(1'b1, $urandom(), 2'd0, 1'b1, 1'b1);
    step(1'b1, $urandom(), 2'd0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cur_act && cur_pos == cur.len - 1 && mq.size() == 1) begin
        found = 1'b1;
        break;
      end
      idle(1);
    end
    check("s6_align", 64'(found), 64'd1);
    step(1'b1, $urandom(), 2'd0, 1'b1, 1'b0);
    check("s6_cnt", 64'(bus.fifo_cnt), 64'd1);
    idle(30);
    check("s6_bits", 64'(cap_n), 64'd24);
    check("s6_nogap", 64'(last_cyc - first_cyc + 1), 64'd24);
    check("s6_lasts", 64'(n_last), 64'd3);

    // Reset during bit 5 of a 16-bit word with two words queued.
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom(), 2'd1, 1'($urandom()), 1'($urandom()));
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cur_act && cur_pos == 5) begin
        found = 1'b1;
        break;
      end
      idle(1);
    end
    check("s5_align", 64'(found), 64'd1);
    check("s5_queued", 64'(bus.fifo_cnt), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("s5_so_valid", 64'(bus.so_valid), 64'd0);
    check("s5_so_data", 64'(bus.so_data), 64'd0);
    check("s5_so_last", 64'(bus.so_last), 64'd0);
    check("s5_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check("s5_pi_ready", 64'(bus.pi_ready), 64'd1);
    @(posedge clk);
    #1;
    check("s5_held_valid", 64'(bus.so_valid), 64'd0);
    check("s5_held_ready", 64'(bus.pi_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    clear_stats();
    idle(25);
    check("s5_quiet", 64'(cap_n), 64'd0);

    // Random traffic against the model.
    clear_stats();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom(), 2'($urandom()),
           1'($urandom()), 1'($urandom()));
    end
    idle(200);
    check("rand_lasts", 64'(n_last), 64'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
